// File: rtl/spi_master_if.sv
// SPI master bus bundle: transfer handshake plus serial lines.
//   start, tx_data : transfer request and word to send (into the master)
//   MISO           : serial data from the slave (into the master)
//   MOSI, sclk, CS : serial data, serial clock and slave enable (from the master)
//   busy, done     : transfer in progress / one-cycle end-of-transfer pulse
//   rx_data        : last received word
// Modport master is used by spi_master; modport slave is the opposite view.
interface spi_master_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              MISO;
  logic              MOSI;
  logic              sclk;
  logic              CS;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    input  start, tx_data, MISO,
    output MOSI, sclk, CS, busy, done, rx_data
  );

  modport slave (
    output start, tx_data, MISO,
    input  MOSI, sclk, CS, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master.sv
// SPI master, mode 0 style: sclk idles low, MOSI MSB first, MISO sampled on sclk falling edges.
// Ports:
//   clk  : clock, all state on its rising edge
//   rst  : synchronous active-low reset
//   bus  : spi_master_if.master (start, tx_data, MISO in; MOSI, sclk, CS, busy, done, rx_data out)
// Parameters: DATA_W word length (2..32), CLK_DIV sclk half-period in clk cycles (1..255).
// Build option: define SPI_MASTER_LOOPBACK_EN to feed the RX shifter from the internal MOSI
// register instead of MISO.
// Timing: SETUP holds CS high with sclk low for CLK_DIV cycles, XFER waits one more half-period
// before the first rising edge, then DONE follows the last falling edge by one cycle, giving
// done CLK_DIV*(2*DATA_W+1)+1 cycles after start is accepted.
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input logic         clk,
  input logic         rst,
  spi_master_if.master bus
);
  localparam int unsigned Edges    = 2 * DATA_W;
  localparam int unsigned EdgeW    = $clog2(Edges + 1);
  localparam logic [7:0]  DivLast  = 8'(CLK_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(Edges);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StDone} state_e;

  state_e            state;
  logic [7:0]        div_cnt;
  logic [EdgeW-1:0]  edge_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_reg;
  logic              mosi_r;
  logic              sclk_r;
  logic              cs_r;
  logic              busy_r;
  logic              done_r;
  logic              rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  // mosi_r still holds the bit being sent when the falling edge samples it
  assign rx_bit = mosi_r;
`else
  assign rx_bit = bus.MISO;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= StIdle;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_reg   <= '0;
      mosi_r   <= 1'b0;
      sclk_r   <= 1'b0;
      cs_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          sclk_r <= 1'b0;
          if (bus.start) begin
            tx_shift <= bus.tx_data;
            mosi_r   <= bus.tx_data[DATA_W-1];
            rx_shift <= '0;
            cs_r     <= 1'b1;
            busy_r   <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= StSetup;
          end else begin
            mosi_r <= 1'b0;
            cs_r   <= 1'b0;
            busy_r <= 1'b0;
            state  <= StIdle;
          end
        end
        StSetup: begin
          if (div_cnt == DivLast) begin
            div_cnt <= '0;
            state   <= StXfer;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        StXfer: begin
          if (edge_cnt == EdgeLast) begin
            // all edges issued: finish one cycle after the last falling edge
            state  <= StDone;
            cs_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            mosi_r <= 1'b0;
            rx_reg <= rx_shift;
          end else if (div_cnt == DivLast) begin
            div_cnt  <= '0;
            sclk_r   <= ~sclk_r;
            edge_cnt <= edge_cnt + 1'b1;
            if (sclk_r) begin
              // falling edge: capture RX bit and advance TX in the same cycle
              rx_shift <= {rx_shift[DATA_W-2:0], rx_bit};
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              mosi_r   <= tx_shift[DATA_W-2];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.MOSI    = mosi_r;
  assign bus.sclk    = sclk_r;
  assign bus.CS      = cs_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rx_data = rx_reg;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one instance with CLK_DIV=2 (driven by a slave model) and one with
// CLK_DIV=1 (MISO tied low). Expected values come from the transfer rules: latency formula,
// MSB-first bit order, and the slave word (or the sent word when loopback is built in).
module tb_spi_master;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  spi_master_if #(.DATA_W(W)) bus2 ();
  spi_master_if #(.DATA_W(W)) bus1 ();

  spi_master #(.DATA_W(W), .CLK_DIV(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));
  spi_master #(.DATA_W(W), .CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  always #5 clk = ~clk;

  // Slave model and line monitor, evaluated on the falling clk edge.
  logic [W-1:0] slave_word = '0;
  int           idx = 0;
  int           m2_rises = 0;
  int           m1_rises = 0;
  logic [W-1:0] m2_mosi = '0;
  logic [W-1:0] m1_mosi = '0;
  logic         p2_sclk = 1'b0, p2_cs = 1'b0, p1_sclk = 1'b0, p1_cs = 1'b0;

  always @(negedge clk) begin
    if (bus2.CS === 1'b1 && !p2_cs) begin
      m2_rises = 0; m2_mosi = '0; idx = 0;
    end
    if (!p2_sclk && bus2.sclk === 1'b1) begin
      m2_rises++; m2_mosi = {m2_mosi[W-2:0], bus2.MOSI};
    end
    if (p2_sclk && bus2.sclk === 1'b0) idx++;
    bus2.MISO = (idx < W) ? slave_word[W-1-idx] : 1'b0;
    if (bus1.CS === 1'b1 && !p1_cs) begin
      m1_rises = 0; m1_mosi = '0;
    end
    if (!p1_sclk && bus1.sclk === 1'b1) begin
      m1_rises++; m1_mosi = {m1_mosi[W-2:0], bus1.MOSI};
    end
    p2_sclk = (bus2.sclk === 1'b1);
    p2_cs   = (bus2.CS === 1'b1);
    p1_sclk = (bus1.sclk === 1'b1);
    p1_cs   = (bus1.CS === 1'b1);
  end

  function automatic int exp_lat(input int div);
    return div * (2 * W + 1) + 1;
  endfunction

  function automatic logic [W-1:0] exp_rx(input logic [W-1:0] tx, input logic [W-1:0] word);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return word;
`endif
  endfunction

  // Issue one start pulse (called just after a clk edge); returns cycles to done or -1.
  task automatic run_xfer(input bit use1, input logic [W-1:0] tx, output int lat);
    if (use1) begin bus1.start = 1'b1; bus1.tx_data = tx; end
    else      begin bus2.start = 1'b1; bus2.tx_data = tx; end
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if ((use1 ? bus1.done : bus2.done) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus2.CS, bus2.sclk, bus2.MOSI, bus2.busy, bus2.done, bus2.rx_data} !== 13'b0) begin
        bad++;
        $display("FAIL reset_idle2 cyc=%0d: got CS,sclk,MOSI,busy,done,rx=%b want all 0", i,
                 {bus2.CS, bus2.sclk, bus2.MOSI, bus2.busy, bus2.done, bus2.rx_data});
      end
      total++;
      if ({bus1.CS, bus1.sclk, bus1.MOSI, bus1.busy, bus1.done, bus1.rx_data} !== 13'b0) begin
        bad++;
        $display("FAIL reset_idle1 cyc=%0d: got CS,sclk,MOSI,busy,done,rx=%b want all 0", i,
                 {bus1.CS, bus1.sclk, bus1.MOSI, bus1.busy, bus1.done, bus1.rx_data});
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    slave_word = 8'h3C;
    run_xfer(1'b0, 8'hA5, lat);
    total++;
    if (lat != exp_lat(2)) begin bad++; $display("FAIL basic_lat: got %0d want %0d", lat, exp_lat(2)); end
    total++;
    if (m2_rises != W) begin bad++; $display("FAIL basic_rises: got %0d want %0d", m2_rises, W); end
    total++;
    if (m2_mosi !== 8'hA5) begin bad++; $display("FAIL basic_mosi: got %h want a5", m2_mosi); end
    total++;
    if (bus2.rx_data !== exp_rx(8'hA5, 8'h3C)) begin
      bad++; $display("FAIL basic_rx: got %h want %h", bus2.rx_data, exp_rx(8'hA5, 8'h3C));
    end
    total++;
    if ({bus2.CS, bus2.sclk, bus2.busy} !== 3'b000) begin
      bad++; $display("FAIL basic_done_lines: got CS,sclk,busy=%b want 000", {bus2.CS, bus2.sclk, bus2.busy});
    end
    @(posedge clk); #1;
    total++;
    if (bus2.done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", bus2.done); end
  endtask

  task automatic test_ignore_start();
    int lat;
    int busy_seen;
    slave_word = 8'h69;
    bus2.start = 1'b1; bus2.tx_data = 8'h96;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) begin lat = n; break; end
      if (n == 9)  begin bus2.start = 1'b1; bus2.tx_data = 8'h11; end
      if (n == 10) bus2.start = 1'b0;
    end
    total++;
    if (lat != exp_lat(2)) begin bad++; $display("FAIL ignore_lat: got %0d want %0d", lat, exp_lat(2)); end
    total++;
    if (m2_mosi !== 8'h96) begin bad++; $display("FAIL ignore_mosi: got %h want 96", m2_mosi); end
    total++;
    if (bus2.rx_data !== exp_rx(8'h96, 8'h69)) begin
      bad++; $display("FAIL ignore_rx: got %h want %h", bus2.rx_data, exp_rx(8'h96, 8'h69));
    end
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus2.busy !== 1'b0) busy_seen++;
    end
    total++;
    if (busy_seen != 0) begin bad++; $display("FAIL ignore_no_restart: got busy %0d cycles want 0", busy_seen); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, cs_gaps;
    slave_word = 8'hA6;
    bus2.start = 1'b1; bus2.tx_data = 8'hFF;
    @(posedge clk); #1;
    lat1 = -1; cs_gaps = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) begin lat1 = n; break; end
      if (bus2.CS !== 1'b1) cs_gaps++;
    end
    total++;
    if (lat1 != exp_lat(2)) begin bad++; $display("FAIL b2b_lat1: got %0d want %0d", lat1, exp_lat(2)); end
    total++;
    if (cs_gaps != 0) begin bad++; $display("FAIL b2b_cs_during1: got %0d low cycles want 0", cs_gaps); end
    total++;
    if (m2_mosi !== 8'hFF) begin bad++; $display("FAIL b2b_mosi1: got %h want ff", m2_mosi); end
    total++;
    if (bus2.CS !== 1'b0) begin bad++; $display("FAIL b2b_cs_gap: got %b want 0", bus2.CS); end
    bus2.tx_data = 8'h00;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    total++;
    if ({bus2.CS, bus2.busy, bus2.done} !== 3'b110) begin
      bad++; $display("FAIL b2b_restart: got CS,busy,done=%b want 110", {bus2.CS, bus2.busy, bus2.done});
    end
    lat2 = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) begin lat2 = n; break; end
    end
    total++;
    if (lat2 != exp_lat(2)) begin bad++; $display("FAIL b2b_lat2: got %0d want %0d", lat2, exp_lat(2)); end
    total++;
    if (m2_mosi !== 8'h00) begin bad++; $display("FAIL b2b_mosi2: got %h want 00", m2_mosi); end
    total++;
    if (bus2.rx_data !== exp_rx(8'h00, 8'hA6)) begin
      bad++; $display("FAIL b2b_rx2: got %h want %h", bus2.rx_data, exp_rx(8'h00, 8'hA6));
    end
  endtask

  task automatic test_reset_mid();
    int   rises, lat;
    logic prev;
    slave_word = 8'h0F;
    bus2.start = 1'b1; bus2.tx_data = 8'h96;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (bus2.sclk === 1'b1 && !prev) rises++;
      prev = (bus2.sclk === 1'b1);
      if (rises == 3) break;
    end
    total++;
    if (rises != 3) begin bad++; $display("FAIL rstmid_reach: got %0d rises want 3", rises); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus2.CS, bus2.sclk, bus2.MOSI, bus2.busy, bus2.done, bus2.rx_data} !== 13'b0) begin
      bad++; $display("FAIL rstmid_outputs: got %b want all 0",
                      {bus2.CS, bus2.sclk, bus2.MOSI, bus2.busy, bus2.done, bus2.rx_data});
    end
    @(posedge clk); #1;
    total++;
    if (bus2.done !== 1'b0) begin bad++; $display("FAIL rstmid_no_done: got %b want 0", bus2.done); end
    // start on the very first edge after release must be taken
    rst = 1'b1;
    run_xfer(1'b0, 8'h5A, lat);
    total++;
    if (lat != exp_lat(2)) begin bad++; $display("FAIL rstmid_lat: got %0d want %0d", lat, exp_lat(2)); end
    total++;
    if (m2_mosi !== 8'h5A) begin bad++; $display("FAIL rstmid_mosi: got %h want 5a", m2_mosi); end
    total++;
    if (bus2.rx_data !== exp_rx(8'h5A, 8'h0F)) begin
      bad++; $display("FAIL rstmid_rx: got %h want %h", bus2.rx_data, exp_rx(8'h5A, 8'h0F));
    end
  endtask

  task automatic test_clkdiv1();
    int lat;
    run_xfer(1'b1, 8'hC3, lat);
    total++;
    if (lat != exp_lat(1)) begin bad++; $display("FAIL div1_lat: got %0d want %0d", lat, exp_lat(1)); end
    total++;
    if (m1_rises != W) begin bad++; $display("FAIL div1_rises: got %0d want %0d", m1_rises, W); end
    total++;
    if (m1_mosi !== 8'hC3) begin bad++; $display("FAIL div1_mosi: got %h want c3", m1_mosi); end
    total++;
    if (bus1.rx_data !== exp_rx(8'hC3, 8'h00)) begin
      bad++; $display("FAIL div1_rx: got %h want %h", bus1.rx_data, exp_rx(8'hC3, 8'h00));
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] tx, word;
    for (int i = 0; i < 6; i++) begin
      tx = W'($urandom);
      word = W'($urandom);
      slave_word = word;
      run_xfer(1'b0, tx, lat);
      total++;
      if (lat != exp_lat(2) || m2_mosi !== tx || bus2.rx_data !== exp_rx(tx, word)) begin
        bad++;
        $display("FAIL rand2_%0d: got lat=%0d mosi=%h rx=%h want lat=%0d mosi=%h rx=%h", i, lat,
                 m2_mosi, bus2.rx_data, exp_lat(2), tx, exp_rx(tx, word));
      end
      run_xfer(1'b1, tx, lat);
      total++;
      if (lat != exp_lat(1) || m1_mosi !== tx || bus1.rx_data !== exp_rx(tx, 8'h00)) begin
        bad++;
        $display("FAIL rand1_%0d: got lat=%0d mosi=%h rx=%h want lat=%0d mosi=%h rx=%h", i, lat,
                 m1_mosi, bus1.rx_data, exp_lat(1), tx, exp_rx(tx, 8'h00));
      end
    end
  endtask

  initial begin
    bus2.start = 1'b0; bus2.tx_data = '0;
    bus1.start = 1'b0; bus1.tx_data = '0; bus1.MISO = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the word length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving the sclk half-period in clk cycles (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port start, input, 1 bit: transfer request, sampled on each clk edge.
REQ-006 The block SHALL have port tx_data, input, DATA_W bits: word to send, captured when start is accepted.
REQ-007 The block SHALL have port MISO, input, 1 bit: serial data from the slave.
REQ-008 The block SHALL have port MOSI, output, 1 bit: serial data to the slave, MSB first.
REQ-009 The block SHALL have port sclk, output, 1 bit: serial clock, idle low.
REQ-010 The block SHALL have port CS, output, 1 bit: active-high slave enable, high only during a transfer.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.
REQ-013 The block SHALL have port rx_data, output, DATA_W bits: last received word, held until the next done.

Function
REQ-014 The FSM SHALL have the states IDLE, SETUP, XFER and DONE, and SHALL never enter any other state.
REQ-015 In IDLE, outputs SHALL be CS=0, sclk=0, MOSI=0, busy=0 and done=0.
REQ-016 When start=1 in IDLE or DONE, the block SHALL load tx_data into the TX shift register and go to SETUP.
REQ-017 In SETUP, outputs SHALL be CS=1, busy=1, sclk=0 and MOSI=tx_data[DATA_W-1]; SETUP SHALL last exactly CLK_DIV cycles and then go to XFER.
REQ-018 In XFER, sclk SHALL toggle every CLK_DIV cycles, starting with a rising edge, for exactly DATA_W rising and DATA_W falling edges.
REQ-019 On each sclk falling edge, the block SHALL shift MISO into the RX shift register LSB-side and present the next TX bit on MOSI in the same clk cycle.
REQ-020 After the DATA_W-th falling edge, the block SHALL enter DONE with CS=0, sclk=0, busy=0 and done=1 for exactly one cycle, and rx_data SHALL be updated in that cycle.
REQ-021 From DONE, the block SHALL go to IDLE, or to SETUP if start=1 (back-to-back transfers); CS SHALL be low for at least one cycle between transfers.
REQ-022 done SHALL rise exactly CLK_DIV*(2*DATA_W+1)+1 clk cycles after the edge that accepted start (35 for DATA_W=8, CLK_DIV=2).
REQ-023 start SHALL be ignored in SETUP and XFER, and tx_data changes while busy=1 SHALL NOT affect the transfer in progress.
REQ-024 With CLK_DIV=1, sclk SHALL toggle on every clk cycle with no lost bits.
REQ-025 sclk, CS and MOSI SHALL be driven directly from registers (glitch-free).

Reset
REQ-026 While rst=0 at a clk edge, the block SHALL set state=IDLE, CS=0, sclk=0, MOSI=0, busy=0, done=0, rx_data=0 and clear both shift registers and the divider counter.
REQ-027 A reset asserted mid-transfer SHALL abort it with no done pulse, and rx_data SHALL read 0.
REQ-028 start sampled on the first edge with rst=1 SHALL be accepted normally.

Configuration
REQ-029 When macro SPI_MASTER_LOOPBACK_EN is defined, the RX path SHALL sample the internal MOSI register instead of the MISO port, so rx_data equals tx_data after every transfer.
REQ-030 When SPI_MASTER_LOOPBACK_EN is not defined, the RX path SHALL sample the MISO port, and no loopback logic SHALL be present.

Verification
REQ-031 Reset then idle -> CS=0, sclk=0, MOSI=0, busy=0, done=0 and rx_data=0x00 for 20 cycles.
REQ-032 DATA_W=8, CLK_DIV=2, tx_data=0xA5, MISO driven by a slave model returning 0x3C -> MOSI carries 10100101 MSB first, 8 sclk pulses, done at cycle 35, rx_data=0x3C.
REQ-033 start held high through two transfers (0xFF then 0x00) -> two done pulses, CS low for exactly 1 cycle between them, and the second word sent is 0x00.
REQ-034 start pulse at cycle 10 of a transfer, with tx_data changed to 0x11 -> ignored; the current word and its timing are unchanged.
REQ-035 rst=0 after the 3rd sclk rising edge -> all outputs at reset values on the next edge, no done pulse, and a new 0x5A transfer afterwards completes correctly.
REQ-036 SPI_MASTER_LOOPBACK_EN defined, CLK_DIV=1, tx_data=0xC3 with MISO tied to 0 -> rx_data=0xC3.
